// File: rtl/hamming_pkg.sv
// Shared constants and types for the Hamming(7,4) codec scheduler.
// Codeword position p (1..7) lives at cw[p-1]; parity sits at the power-of-two positions.
package hamming_pkg;

  localparam int SYN_W = 3;

  localparam logic MODE_ENC = 1'b0;
  localparam logic MODE_DEC = 1'b1;

  localparam int P1_POS = 0;
  localparam int P2_POS = 1;
  localparam int P4_POS = 3;
  localparam int D0_POS = 2;
  localparam int D1_POS = 4;
  localparam int D2_POS = 5;
  localparam int D3_POS = 6;

  typedef enum logic {ST_EMPTY, ST_FULL} out_state_t;

  typedef struct packed {
    logic             mode;
    logic [6:0]       word;
    logic [SYN_W-1:0] syn;
    logic             err;
  } result_t;

endpackage

// File: rtl/hamming74_codec.sv
// Combinational Hamming(7,4) even-parity encoder / single-error-correcting decoder.
// Zero latency; no flow control. Outputs of the unused direction are forced to zero.
module hamming74_codec
  import hamming_pkg::*;
(
  input  logic             mode,
  input  logic [3:0]       d,
  input  logic [6:0]       cw,
  output logic [6:0]       code,
  output logic [3:0]       data,
  output logic [SYN_W-1:0] syn
);

  logic [6:0] cw_fix;

  always_comb begin
    code   = '0;
    data   = '0;
    syn    = '0;
    cw_fix = cw;
    if (mode == MODE_ENC) begin
      code[D0_POS] = d[0];
      code[D1_POS] = d[1];
      code[D2_POS] = d[2];
      code[D3_POS] = d[3];
      code[P1_POS] = d[0] ^ d[1] ^ d[3];
      code[P2_POS] = d[0] ^ d[2] ^ d[3];
      code[P4_POS] = d[1] ^ d[2] ^ d[3];
    end else begin
      syn[0] = cw[0] ^ cw[2] ^ cw[4] ^ cw[6];
      syn[1] = cw[1] ^ cw[2] ^ cw[5] ^ cw[6];
      syn[2] = cw[3] ^ cw[4] ^ cw[5] ^ cw[6];
      // The syndrome is the 1-based position of the flipped bit.
      for (int p = 1; p <= 7; p++) begin
        if (int'(syn) == p) cw_fix[p-1] = ~cw[p-1];
      end
      data = {cw_fix[D3_POS], cw_fix[D2_POS], cw_fix[D1_POS], cw_fix[D0_POS]};
    end
  end

endmodule

// File: rtl/hamming_codec_sched.sv
// Round-robin scheduler sharing one Hamming(7,4) codec between encode and decode requesters.
// Result registered one cycle after acceptance; both readys drop while the full result register is stalled.
module hamming_codec_sched
  import hamming_pkg::*;
#(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             enc_valid,
  input  logic [3:0]       enc_data,
  output logic             enc_ready,
  input  logic             dec_valid,
  input  logic [6:0]       dec_code,
  output logic             dec_ready,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             out_mode,
  output logic [6:0]       out_word,
  output logic [SYN_W-1:0] out_syn,
  output logic             out_err,
  input  logic             cnt_clr,
  output logic [CNT_W-1:0] err_cnt
);

  localparam logic [CNT_W-1:0] CNT_MAX = '1;
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  out_state_t       state;
  result_t          res;
  result_t          next_res;
  logic             last_dec;
  logic             can_load;
  logic             grant_enc;
  logic             grant_dec;
  logic             accept;
  logic             mode;
  logic [6:0]       code;
  logic [3:0]       data;
  logic [SYN_W-1:0] syn;

  // Encode wins contention unless it was the last side granted.
  assign can_load  = (state == ST_EMPTY) || out_ready;
  assign grant_enc = enc_valid && (!dec_valid || last_dec);
  assign grant_dec = dec_valid && !grant_enc;
  assign enc_ready = can_load && grant_enc;
  assign dec_ready = can_load && grant_dec;
  assign accept    = enc_ready || dec_ready;
  assign mode      = grant_dec ? MODE_DEC : MODE_ENC;

  hamming74_codec u_codec (
    .mode (mode),
    .d    (enc_data),
    .cw   (dec_code),
    .code (code),
    .data (data),
    .syn  (syn)
  );

  always_comb begin
    next_res      = '0;
    next_res.mode = mode;
    next_res.word = (mode == MODE_DEC) ? {3'b000, data} : code;
    next_res.syn  = syn;
    next_res.err  = (syn != '0);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= ST_EMPTY;
      res      <= '0;
      last_dec <= 1'b1;
    end else begin
      case (state)
        ST_EMPTY: if (accept) state <= ST_FULL;
        ST_FULL:  if (out_ready && !accept) state <= ST_EMPTY;
        default:  state <= ST_EMPTY;
      endcase
      if (accept) begin
        res      <= next_res;
        last_dec <= dec_ready;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      err_cnt <= '0;
    end else if (cnt_clr) begin
      err_cnt <= '0;
    end else if (dec_ready && (syn != '0) && (err_cnt != CNT_MAX)) begin
      err_cnt <= err_cnt + CNT_ONE;
    end
  end

  assign out_valid = (state == ST_FULL);
  assign out_mode  = res.mode;
  assign out_word  = res.word;
  assign out_syn   = res.syn;
  assign out_err   = res.err;

endmodule
